// File: rtl/ir_transmitter.sv
// NEC infrared frame transmitter: leader, 32 pulse-distance bits (MSB first), stop mark, then a
// guard gap. Drives both the demodulated line level and the carrier-modulated LED signal.
module ir_transmitter #(
    parameter int unsigned UNIT         = 28125,
    parameter int unsigned CARRIER_HALF = 658,
    parameter int unsigned GAP_UNITS    = 71
) (
    input  logic        nec_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] word,
    output logic        ir_out,
    output logic        carrier_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned LEAD_LEN  = 16 * UNIT;
    localparam int unsigned GAP_LEN   = GAP_UNITS * UNIT;
    localparam int unsigned MAX_DUR   = (LEAD_LEN > GAP_LEN) ? LEAD_LEN : GAP_LEN;
    localparam int unsigned DUR_RAW_W = $clog2(MAX_DUR + 1);
    localparam int unsigned DUR_W     = (DUR_RAW_W > 24) ? DUR_RAW_W : 24;
    localparam int unsigned CAR_RAW_W = $clog2(CARRIER_HALF + 1);
    localparam int unsigned CAR_W     = (CAR_RAW_W > 1) ? CAR_RAW_W : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [31:0]        shift_q, shift_d;
    logic [CAR_W-1:0]   car_cnt_q, car_cnt_d;
    logic               carrier_q, carrier_d;
    logic               ir_q, ir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               seg_last;
    logic               mark_now;
    logic               mark_next;

    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        seg_last  = (dur_q == '0);

        // dur_q holds cycles remaining minus one, so a segment loaded with N-1 lasts N cycles
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LEAD_MARK;
                    dur_d     = DUR_W'(LEAD_LEN - 1);
                    shift_d   = word;
                    bit_cnt_d = 6'd31;
                end
            end
            LEAD_MARK: begin
                if (seg_last) begin
                    state_d = LEAD_SPACE;
                    dur_d   = DUR_W'(8 * UNIT - 1);
                end else begin
                    dur_d = dur_q - DUR_W'(1);
                end
            end
            LEAD_SPACE: begin
                if (seg_last) begin
                    state_d = BIT_MARK;
                    dur_d   = DUR_W'(UNIT - 1);
                end else begin
                    dur_d = dur_q - DUR_W'(1);
                end
            end
            BIT_MARK: begin
                if (seg_last) begin
                    state_d = BIT_SPACE;
                    dur_d   = shift_q[31] ? DUR_W'(3 * UNIT - 1) : DUR_W'(UNIT - 1);
                end else begin
                    dur_d = dur_q - DUR_W'(1);
                end
            end
            BIT_SPACE: begin
                if (seg_last) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    dur_d   = DUR_W'(UNIT - 1);
                    if (bit_cnt_q == 6'd0) begin
                        state_d = STOP_MARK;
                    end else begin
                        state_d   = BIT_MARK;
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end else begin
                    dur_d = dur_q - DUR_W'(1);
                end
            end
            STOP_MARK: begin
                if (seg_last) begin
                    state_d = GAP;
                    dur_d   = DUR_W'(GAP_LEN - 1);
                end else begin
                    dur_d = dur_q - DUR_W'(1);
                end
            end
            GAP: begin
                if (seg_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    dur_d = dur_q - DUR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state
    always_comb begin
        mark_now  = (state_q == LEAD_MARK) || (state_q == BIT_MARK) || (state_q == STOP_MARK);
        mark_next = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);
        ir_d      = ~mark_next;
        busy_d    = (state_d != IDLE);
        carrier_d = 1'b0;
        car_cnt_d = '0;
        if (mark_next) begin
            if (!mark_now) begin
                carrier_d = 1'b1;
                car_cnt_d = CAR_W'(CARRIER_HALF - 1);
            end else if (car_cnt_q == '0) begin
                carrier_d = ~carrier_q;
                car_cnt_d = CAR_W'(CARRIER_HALF - 1);
            end else begin
                carrier_d = carrier_q;
                car_cnt_d = car_cnt_q - CAR_W'(1);
            end
        end
    end

    always_ff @(posedge nec_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dur_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            car_cnt_q <= '0;
            carrier_q <= 1'b0;
            ir_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            car_cnt_q <= car_cnt_d;
            carrier_q <= carrier_d;
            ir_q      <= ir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ir_out      = ir_q;
    assign carrier_out = carrier_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
